wasm_convert_unit: RTL

Multi-cycle numeric conversion unit for the WebAssembly CPU datapath. Covers the reinterpret, wrap, extend and float-to-int truncate operator family, with USE_64B and HAS_FPU gating. Sits beside the ALU/FPU and is driven by the opcode decoder over a valid/ready handshake. Returns a typed result or a trap code.

---
 rtl/wasm_convert_unit.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/wasm_convert_unit.sv
// rtl/wasm_convert_unit.sv - WebAssembly reinterpret/wrap/extend/truncate conversion unit
// Optional saturating truncate prefix (op 7) enabled by CONVERT_SAT_TRUNC_EN.
module wasm_convert_unit #(
    parameter logic HAS_FPU    = 1'b1,
    parameter logic USE_64B    = 1'b1,
    parameter int   SHIFT_STEP = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result,
    output logic [1:0]  result_type,
    output logic [3:0]  trap
);

    localparam logic [1:0] TYPE_I32 = 2'd0;
    localparam logic [1:0] TYPE_I64 = 2'd1;
    localparam logic [1:0] TYPE_F32 = 2'd2;
    localparam logic [1:0] TYPE_F64 = 2'd3;

    localparam logic [3:0] TRAP_NONE               = 4'd0;
    localparam logic [3:0] TRAP_ILLEGAL_OP         = 4'd1;
    localparam logic [3:0] TRAP_NO_FPU             = 4'd2;
    localparam logic [3:0] TRAP_NO_64B             = 4'd3;
    localparam logic [3:0] TRAP_INTEGER_OVERFLOW   = 4'd4;
    localparam logic [3:0] TRAP_INVALID_CONVERSION = 4'd5;

    localparam logic [6:0] STEP = 7'(SHIFT_STEP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        accept;
    logic        sat_active;

    logic [63:0] mant;
    logic [6:0]  rem;
    logic        shift_left;
    logic        negate;
    logic        dst64;
    logic [6:0]  step_amt;
    logic [63:0] mant_next;

    logic [63:0] acc_result;
    logic [1:0]  acc_type;
    logic [3:0]  acc_trap;
    logic [63:0] acc_mant;
    logic [6:0]  acc_rem;
    logic        acc_left;
    logic        acc_neg;
    logic        acc_prefix;

    logic               need_fpu;
    logic               need_64b;
    logic               sgn;
    logic               exp_max;
    logic               frac_nz;
    logic               zero_exp;
    logic               uns;
    logic               ovf;
    logic signed [12:0] e_unb;
    logic signed [12:0] fbits;
    logic signed [12:0] n_s;
    logic signed [12:0] s_val;
    logic [12:0]        s_abs;
    logic [63:0]        mant_in;

    function automatic logic [63:0] finalize(input logic [63:0] mag, input logic neg,
                                             input logic wide);
        logic [63:0] v;
        v = neg ? (~mag + 64'd1) : mag;
        return wide ? v : {32'd0, v[31:0]};
    endfunction

    function automatic logic [63:0] sat_value(input logic wide, input logic unsig,
                                              input logic neg);
        if (unsig)
            return neg ? 64'd0 : (wide ? {64{1'b1}} : 64'h00000000FFFFFFFF);
        if (neg)
            return wide ? 64'h8000000000000000 : 64'h0000000080000000;
        return wide ? 64'h7FFFFFFFFFFFFFFF : 64'h000000007FFFFFFF;
    endfunction

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready;

`ifdef CONVERT_SAT_TRUNC_EN
    logic sat_flag;
    assign sat_active = sat_flag;
`else
    assign sat_active = 1'b0;
`endif

    assign step_amt  = (rem > STEP) ? STEP : rem;
    assign mant_next = shift_left ? (mant << step_amt) : (mant >> step_amt);

    // Field decode for the truncate family; harmless for other ops.
    always_comb begin
        uns = in_op[0];
        if (in_op[1]) begin
            sgn      = in_data[63];
            exp_max  = &in_data[62:52];
            zero_exp = (in_data[62:52] == 11'd0);
            frac_nz  = |in_data[51:0];
            e_unb    = $signed({2'b00, in_data[62:52]}) - 13'sd1023;
            fbits    = 13'sd52;
            mant_in  = {11'd0, 1'b1, in_data[51:0]};
        end else begin
            sgn      = in_data[31];
            exp_max  = &in_data[30:23];
            zero_exp = (in_data[30:23] == 8'd0);
            frac_nz  = |in_data[22:0];
            e_unb    = $signed({5'd0, in_data[30:23]}) - 13'sd127;
            fbits    = 13'sd23;
            mant_in  = {40'd0, 1'b1, in_data[22:0]};
        end
        n_s   = in_op[2] ? 13'sd64 : 13'sd32;
        s_val = e_unb - fbits;
        s_abs = s_val[12] ? $unsigned(-s_val) : $unsigned(s_val);
        // Exactly -2^(N-1) is the one signed value with E = N-1 that fits.
        if (uns)
            ovf = (e_unb >= n_s) || (sgn && e_unb >= 13'sd0);
        else
            ovf = (e_unb >= n_s - 13'sd1) &&
                  !(sgn && e_unb == n_s - 13'sd1 && !frac_nz);
    end

    always_comb begin
        acc_result = 64'd0;
        acc_type   = TYPE_I32;
        acc_trap   = TRAP_NONE;
        acc_mant   = 64'd0;
        acc_rem    = 7'd0;
        acc_left   = 1'b0;
        acc_neg    = 1'b0;
        acc_prefix = 1'b0;
        need_fpu   = 1'b0;
        need_64b   = 1'b0;
        case (in_op)
            4'd0: begin acc_type = TYPE_I32; need_fpu = 1'b1;
                        acc_result = {32'd0, in_data[31:0]}; end
            4'd1: begin acc_type = TYPE_I64; need_fpu = 1'b1; need_64b = 1'b1;
                        acc_result = in_data; end
            4'd2: begin acc_type = TYPE_F32; need_fpu = 1'b1;
                        acc_result = {32'd0, in_data[31:0]}; end
            4'd3: begin acc_type = TYPE_F64; need_fpu = 1'b1; need_64b = 1'b1;
                        acc_result = in_data; end
            4'd4: begin acc_type = TYPE_I32; need_64b = 1'b1;
                        acc_result = {32'd0, in_data[31:0]}; end
            4'd5: begin acc_type = TYPE_I64; need_64b = 1'b1;
                        acc_result = {{32{in_data[31]}}, in_data[31:0]}; end
            4'd6: begin acc_type = TYPE_I64; need_64b = 1'b1;
                        acc_result = {32'd0, in_data[31:0]}; end
            4'd7: acc_type = TYPE_I32;
            default: begin
                acc_type = in_op[2] ? TYPE_I64 : TYPE_I32;
                need_fpu = 1'b1;
                need_64b = in_op[2] | in_op[1];
            end
        endcase

        if (in_op == 4'd7) begin
`ifdef CONVERT_SAT_TRUNC_EN
            acc_prefix = 1'b1;
`else
            acc_trap   = TRAP_ILLEGAL_OP;
`endif
        end else if (need_fpu && !HAS_FPU) begin
            acc_trap   = TRAP_NO_FPU;
            acc_result = 64'd0;
        end else if (need_64b && !USE_64B) begin
            acc_trap   = TRAP_NO_64B;
            acc_result = 64'd0;
        end else if (in_op[3]) begin
            if (exp_max && frac_nz) begin
                if (!sat_active)
                    acc_trap = TRAP_INVALID_CONVERSION;
            end else if (exp_max || ovf) begin
                if (sat_active)
                    acc_result = sat_value(in_op[2], uns, sgn);
                else
                    acc_trap = TRAP_INTEGER_OVERFLOW;
            end else if (!zero_exp && e_unb >= 13'sd0) begin
                acc_mant = mant_in;
                acc_neg  = sgn & ~uns;
                acc_left = !s_val[12];
                acc_rem  = 7'(s_abs);
                if (s_val == 13'sd0)
                    acc_result = finalize(mant_in, sgn & ~uns, in_op[2]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept && !acc_prefix)
                         state_next = (acc_rem != 7'd0) ? S_SHIFT : S_DONE;
            S_SHIFT: if (rem <= STEP) state_next = S_DONE;
            S_DONE:  if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result      <= 64'd0;
            result_type <= TYPE_I32;
            trap        <= TRAP_NONE;
            mant        <= 64'd0;
            rem         <= 7'd0;
            shift_left  <= 1'b0;
            negate      <= 1'b0;
            dst64       <= 1'b0;
`ifdef CONVERT_SAT_TRUNC_EN
            sat_flag    <= 1'b0;
`endif
        end else if (state == S_IDLE && accept) begin
`ifdef CONVERT_SAT_TRUNC_EN
            sat_flag <= acc_prefix;
`endif
            if (!acc_prefix) begin
                result      <= acc_result;
                result_type <= acc_type;
                trap        <= acc_trap;
                mant        <= acc_mant;
                rem         <= acc_rem;
                shift_left  <= acc_left;
                negate      <= acc_neg;
                dst64       <= in_op[2];
            end
        end else if (state == S_SHIFT) begin
            mant <= mant_next;
            rem  <= rem - step_amt;
            if (rem <= STEP)
                result <= finalize(mant_next, negate, dst64);
        end
    end

endmodule
